score_ssd_driver: RTL
=====================

Name: score_ssd_driver

Overview:
- Consumes the 16-bit binary score produced by the pacman movement stage and drives the eight-digit seven-segment display.
- A sequential double-dabble engine converts the score to five BCD digits only when the score changes.
- A time-multiplexed scanner drives the active-low anodes and cathodes, with optional leading-zero blanking.
- Sits between pacman_movement (score source) and the board SSD pins.

Parameters:
SCORE_W, 16, width of binary score input; fixed at 16 for 5 BCD digits (0..65535).
SCAN_BIT, 17, scan counter LSB selecting the digit index; 100 MHz / 2^17 gives about 763 Hz per digit.
LZB, 1, 1 = blank leading zeros on digits 4..1; 0 = show all five digits.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
score  input  16  binary score from the movement stage.
busy  output  1  high while a conversion is in progress.
an  output  8  active-low anode enables; an[i] drives digit i (0 = rightmost).
seg  output  7  active-low cathodes, order {a,b,c,d,e,f,g}.
dp  output  1  decimal point, active-low; constant 1 (off) after reset.

Behaviour:
- Reset (reset==0 at an edge) sets:
  - scan counter = 0, digit regs d4..d0 = 0, FSM = IDLE, force flag = 1, busy = 0.
  - an = 8'b11111110, seg = 7'b0000001 (digit 0 shows "0"), dp = 1.
  - Reset mid-conversion aborts the conversion; the display returns to "0".
- Conversion FSM states: IDLE, SHIFT, LOAD.
- IDLE:
  - If force==1 or score != last_score: latch score into shift reg and last_score, clear the 20-bit BCD accumulator, set iteration count = 0, set busy = 1, clear force, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (one iteration per cycle, 16 cycles):
  - Each BCD nibble >= 5 gets +3.
  - {bcd, shift} is then shifted left by 1 in the same cycle.
  - After the 16th iteration, go to LOAD.
- LOAD:
  - Copy the BCD nibbles to d4..d0 and set busy = 0, both in the same cycle.
  - Return to IDLE.
- Latency: score sampled at IDLE edge k → d4..d0 valid after edge k+17 → seg reflects the new digits from the next registered output update (edge k+18).
- Changes on score during SHIFT/LOAD are ignored. IDLE re-compares against last_score, so the final value always converges.
- A score that returns to last_score while busy triggers no further conversion.
- d4..d0 hold their previous value throughout conversion, so the display never shows partial results.
- Scanner:
  - Free-running counter of width SCAN_BIT+3; wraps from all-ones to 0.
  - Digit index idx = counter[SCAN_BIT+2:SCAN_BIT].
- Outputs an and seg are registered and update every clk:
  - an = ~(8'b1 << idx).
  - idx 5..7: seg = 7'b1111111 (blank).
  - idx 0: always shows d0.
  - idx i in 1..4 with LZB==1: blank if d4..di are all zero; otherwise show di.
  - LZB==0: all of d4..d0 are shown.
- Cathode codes (abcdefg, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Nibble values above 9 cannot occur; map them to blank.
- Output registers lag the counter by one cycle: an and seg are mutually consistent, and both are one cycle late relative to idx.

Test Plan (bench uses SCAN_BIT=2):
- Reset: hold reset=0 for 3 cycles with score=0 → an=8'hFE, seg=7'b0000001, dp=1, busy=0. After release, one forced conversion runs: busy=1 for exactly 17 cycles, and digits stay 0.
- Conversion: score=16'd1234 → busy high for 17 cycles. Then d3..d0 = 1,2,3,4; on idx=3 seg=7'b1001111, on idx=0 seg=7'b1001100; idx=4 blank (LZB=1).
- Max value: score=16'd65535 → d4..d0 = 6,5,5,3,5; idx=4 seg=7'b0100000. No blanking on any of d4..d0.
- Mid-conversion change: score=100 then score=250 at cycle 5 of SHIFT → display shows 100, then a second conversion starts, and the display settles at 250 with total busy of 34 cycles (plus 1 IDLE cycle).
- Scan wrap: run 2^(SCAN_BIT+3)=32 cycles → an walks FE,FD,FB,F7,EF,DF,BF,7F then back to FE. idx 5..7 show seg=7'h7F.
- Reset mid-conversion: assert reset at SHIFT cycle 8 with score=999 → outputs return to the reset values on the next edge. After release, the forced conversion displays 999.

Source files
------------

// File: rtl/score_ssd_driver_if.sv
// Score-to-display bus: binary score in, conversion status and SSD pin drives out.
interface score_ssd_driver_if #(
    parameter int SCORE_W = 16
);
    logic [SCORE_W-1:0] score;
    logic               busy;
    logic [7:0]         an;
    logic [6:0]         seg;
    logic               dp;

    modport master (output score, input busy, an, seg, dp);
    modport slave  (input score, output busy, an, seg, dp);
endinterface

// File: rtl/score_ssd_driver.sv
// Converts the 16-bit score to BCD with a sequential double-dabble engine and
// time-multiplexes five digits onto the eight-digit active-low SSD.
module score_ssd_driver #(
    parameter int SCORE_W  = 16,
    parameter int SCAN_BIT = 17,
    parameter int LZB      = 1
) (
    input  logic              clk,
    input  logic              reset,
    score_ssd_driver_if.slave bus
);
    localparam int CNT_W = SCAN_BIT + 3;
    localparam int BCD_W = 20;
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     scan_q, scan_d;
    logic [4:0][3:0]      dig_q, dig_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [SCORE_W-1:0]   shift_q, shift_d;
    logic [SCORE_W-1:0]   last_q, last_d;
    logic [3:0]           iter_q, iter_d;
    logic                 force_q, force_d;
    logic                 busy_q, busy_d;
    logic [7:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;

    logic                 start;
    logic [4:0][3:0]      bcd_adj;
    logic [2:0]           idx;
    logic [4:1]           hi_zero;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b0000001;
            4'd1:    seg_code = 7'b1001111;
            4'd2:    seg_code = 7'b0010010;
            4'd3:    seg_code = 7'b0000110;
            4'd4:    seg_code = 7'b1001100;
            4'd5:    seg_code = 7'b0100100;
            4'd6:    seg_code = 7'b0100000;
            4'd7:    seg_code = 7'b0001111;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0000100;
            default: seg_code = BLANK;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            scan_q  <= '0;
            dig_q   <= '0;
            bcd_q   <= '0;
            shift_q <= '0;
            last_q  <= '0;
            iter_q  <= '0;
            force_q <= 1'b1;
            busy_q  <= 1'b0;
            an_q    <= 8'b11111110;
            seg_q   <= 7'b0000001;
        end else begin
            state_q <= state_d;
            scan_q  <= scan_d;
            dig_q   <= dig_d;
            bcd_q   <= bcd_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            iter_q  <= iter_d;
            force_q <= force_d;
            busy_q  <= busy_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign start = force_q || (bus.score != last_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (iter_q == 4'd15) state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Conversion datapath; digit registers only change in LOAD so the
    // display never sees a half-converted value.
    always_comb begin
        dig_d   = dig_q;
        bcd_d   = bcd_q;
        shift_d = shift_q;
        last_d  = last_q;
        iter_d  = iter_q;
        force_d = force_q;
        busy_d  = busy_q;
        for (int i = 0; i < 5; i++) begin
            bcd_adj[i] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = bus.score;
                    last_d  = bus.score;
                    bcd_d   = '0;
                    iter_d  = '0;
                    busy_d  = 1'b1;
                    force_d = 1'b0;
                end
            end
            SHIFT: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                iter_d = iter_q + 4'd1;
            end
            LOAD: begin
                dig_d  = bcd_q;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Scanner: registered an/seg both trail the counter by one cycle.
    assign idx = scan_q[SCAN_BIT+2:SCAN_BIT];

    always_comb begin
        hi_zero[4] = (dig_q[4] == 4'd0);
        for (int i = 3; i >= 1; i--) begin
            hi_zero[i] = hi_zero[i+1] && (dig_q[i] == 4'd0);
        end
    end

    always_comb begin
        scan_d = scan_q + 1'b1;
        an_d   = ~(8'b1 << idx);
        case (idx)
            3'd0:                   seg_d = seg_code(dig_q[0]);
            3'd1, 3'd2, 3'd3, 3'd4: seg_d = ((LZB != 0) && hi_zero[idx]) ? BLANK : seg_code(dig_q[idx]);
            default:                seg_d = BLANK;
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
    assign bus.dp   = 1'b1;
endmodule
